mac_window_ctrl: RTL and testbench

Sequencer for the NUM_MACS-lane MAC array. Accepts a convolution job descriptor, then for each output window clears the array, streams cfg_len operand-vector reads from the A/B operand buffers, and issues a zero-operand flush beat. It then captures the array's dot product into a one-entry result register with valid/ready backpressure. It sits between the job scheduler (config side), the operand SRAMs (read side), the MAC array (start/valid side) and the output writer (result side).

---
 rtl/mac_window_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mac_window_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_window_ctrl.sv
// mac_window_ctrl
//   Sequencer for the MAC array. Takes one convolution job descriptor, then
//   for every output window: clears the array, streams cfg_len operand reads
//   from the A/B buffers, issues a zero-operand flush beat, waits for the
//   array to drain and captures its dot product into a one-entry result
//   register with valid/ready backpressure.
//
//   Ports
//     clk, rst              clock, synchronous active-high reset
//     cfg_valid/cfg_ready   job descriptor handshake (ready only when idle)
//     cfg_a_base/b_base     window-0 start addresses of the A/B buffers
//     cfg_a_stride/b_stride per-window base increments (wrap modulo 2^ADDR_W)
//     cfg_len               operand beats per window
//     cfg_windows           windows in the job
//     rd_en, rd_addr_a/b    operand read strobe and addresses (1-cycle SRAM)
//     mac_start             one-cycle array clear
//     mac_valid             array accumulate enable
//     op_zero               forces array operands to zero (flush beat)
//     mac_dot               array dot product
//     res_valid/res_ready   result handshake
//     res_data, res_last    captured dot product, final-window flag
//     busy                  high whenever not idle
//     done                  one-cycle pulse at job completion
module mac_window_ctrl #(
  parameter int NUM_MACS = 4,
  parameter int ADDR_W   = 10,
  parameter int LEN_W    = 8,
  parameter int WIN_W    = 8,
  parameter int DOT_W    = 36,
  parameter int DRAIN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_a_base,
  input  logic [ADDR_W-1:0] cfg_b_base,
  input  logic [ADDR_W-1:0] cfg_a_stride,
  input  logic [ADDR_W-1:0] cfg_b_stride,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [WIN_W-1:0]  cfg_windows,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              mac_start,
  output logic              mac_valid,
  output logic              op_zero,
  input  logic [DOT_W-1:0]  mac_dot,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DOT_W-1:0]  res_data,
  output logic              res_last,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_READ    = 3'd2;
  localparam logic [2:0] S_FLUSH   = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  // The controller is lane-count agnostic; NUM_MACS only documents the
  // width of the attached array and must be at least one lane.
  if (NUM_MACS < 1) begin : g_no_lanes
  end

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_base_a;
  logic [ADDR_W-1:0] r_base_b;
  logic [ADDR_W-1:0] r_stride_a;
  logic [ADDR_W-1:0] r_stride_b;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat;
  logic [WIN_W-1:0]  r_windows;
  logic [WIN_W-1:0]  r_win;
  logic [2:0]        r_drn;
  logic              r_rd_en_d;
  logic              r_res_valid;
  logic [DOT_W-1:0]  r_res_data;
  logic              r_res_last;

  logic w_rd_en;
  logic w_cap_ok;
  logic w_drain_end;
  logic w_capture;
  logic w_last_win;
  logic w_done;

  // READ spans len+1 cycles: len strobes, then one idle cycle in which the
  // last data beat is accumulated, so the flush beat never overlaps data.
  assign w_rd_en     = (r_state == S_READ) && (r_beat != r_len);
  assign w_cap_ok    = !r_res_valid || res_ready;
  assign w_drain_end = (r_drn == 3'(DRAIN - 1));
  // Capture is attempted in the final drain cycle; if the result register
  // is still occupied the FSM parks in CAPTURE until it frees up.
  assign w_capture   = ((r_state == S_DRAIN && w_drain_end) ||
                        (r_state == S_CAPTURE)) && w_cap_ok;
  assign w_last_win  = (r_win == r_windows - WIN_W'(1));
  assign w_done      = (r_state == S_FINISH) && w_cap_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base_a    <= '0;
      r_base_b    <= '0;
      r_stride_a  <= '0;
      r_stride_b  <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_windows   <= '0;
      r_win       <= '0;
      r_drn       <= '0;
      r_rd_en_d   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_last  <= 1'b0;
    end else begin
      r_rd_en_d <= w_rd_en;

      if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (cfg_valid) begin
            r_base_a   <= cfg_a_base;
            r_base_b   <= cfg_b_base;
            r_stride_a <= cfg_a_stride;
            r_stride_b <= cfg_b_stride;
            r_len      <= cfg_len;
            r_windows  <= cfg_windows;
            r_win      <= '0;
            r_state    <= (cfg_windows == '0) ? S_FINISH : S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_beat  <= '0;
          r_state <= (r_len == '0) ? S_FLUSH : S_READ;
        end
        S_READ: begin
          if (r_beat == r_len) begin
            r_state <= S_FLUSH;
          end else begin
            r_beat <= r_beat + LEN_W'(1);
          end
        end
        S_FLUSH: begin
          r_drn   <= '0;
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!w_drain_end) begin
            r_drn <= r_drn + 3'd1;
          end else if (!w_cap_ok) begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
        end
        S_FINISH: begin
          if (w_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Shared exit path of DRAIN and CAPTURE; overrides the case above.
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_data  <= mac_dot;
        r_res_last  <= w_last_win;
        if (w_last_win) begin
          r_state <= S_FINISH;
        end else begin
          r_base_a <= r_base_a + r_stride_a;
          r_base_b <= r_base_b + r_stride_b;
          r_win    <= r_win + WIN_W'(1);
          r_state  <= S_CLEAR;
        end
      end
    end
  end

  assign cfg_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rd_en     = w_rd_en;
  assign rd_addr_a = r_base_a + ADDR_W'(r_beat);
  assign rd_addr_b = r_base_b + ADDR_W'(r_beat);
  assign mac_start = (r_state == S_CLEAR);
  assign mac_valid = r_rd_en_d || (r_state == S_FLUSH);
  assign op_zero   = (r_state == S_FLUSH);
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_last  = r_res_last;
  assign done      = w_done;

endmodule

// File: tb/tb_mac_window_ctrl.sv
// Testbench for mac_window_ctrl: operand SRAM and MAC array behavioural
// models drive the DUT; expected results and read addresses come from a
// window/beat arithmetic model of the job.
module tb_mac_window_ctrl;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 8;
  localparam int WIN_W  = 8;
  localparam int DOT_W  = 36;
  localparam int LANES  = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_a_base = '0;
  logic [ADDR_W-1:0] cfg_b_base = '0;
  logic [ADDR_W-1:0] cfg_a_stride = '0;
  logic [ADDR_W-1:0] cfg_b_stride = '0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [WIN_W-1:0]  cfg_windows = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              mac_start;
  logic              mac_valid;
  logic              op_zero;
  logic [DOT_W-1:0]  mac_dot;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [DOT_W-1:0]  res_data;
  logic              res_last;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  mac_window_ctrl #(
    .NUM_MACS(LANES),
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .WIN_W   (WIN_W),
    .DOT_W   (DOT_W),
    .DRAIN   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_a_base  (cfg_a_base),
    .cfg_b_base  (cfg_b_base),
    .cfg_a_stride(cfg_a_stride),
    .cfg_b_stride(cfg_b_stride),
    .cfg_len     (cfg_len),
    .cfg_windows (cfg_windows),
    .rd_en       (rd_en),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .mac_start   (mac_start),
    .mac_valid   (mac_valid),
    .op_zero     (op_zero),
    .mac_dot     (mac_dot),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_last    (res_last),
    .busy        (busy),
    .done        (done)
  );

  // ---------------- environment: operand SRAMs and MAC array -------------
  logic [7:0]        mem_a [DEPTH][LANES];
  logic [7:0]        mem_b [DEPTH][LANES];
  logic [ADDR_W-1:0] q_addr_a;
  logic [ADDR_W-1:0] q_addr_b;
  logic [DOT_W-1:0]  acc;

  function automatic logic [DOT_W-1:0] dotp(input int unsigned aa, input int unsigned bb);
    logic [DOT_W-1:0] s;
    s = '0;
    for (int l = 0; l < LANES; l++)
      s += DOT_W'(mem_a[aa][l]) * DOT_W'(mem_b[bb][l]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      q_addr_a <= rd_addr_a;
      q_addr_b <= rd_addr_b;
    end
  end

  always @(posedge clk) begin
    if (rst || mac_start) acc <= '0;
    else if (mac_valid && !op_zero) acc <= acc + dotp(int'(q_addr_a), int'(q_addr_b));
  end
  assign mac_dot = acc;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------------------------------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  typedef struct { logic [DOT_W-1:0] data; logic last; } res_t;
  typedef struct { int unsigned a; int unsigned b; } rd_t;

  res_t             exp_res[$];
  rd_t              exp_rd[$];
  logic [DOT_W-1:0] got_data[$];
  logic             got_last[$];
  int unsigned      got_addr_a[$];

  bit   mon_en = 1'b0;
  int   t0 = 0;
  int   n_start, n_rd, n_mv, n_done;
  int   first_start, first_rd, last_rd, first_oz, first_rv, done_rel;
  int   m_rel;
  rd_t  m_rd;
  res_t m_res;

  always @(negedge clk) begin : monitor
    if (mon_en && !rst) begin
      m_rel = cyc - t0;
      if (mac_start) begin
        n_start++;
        if (first_start < 0) first_start = m_rel;
      end
      if (mac_valid) n_mv++;
      if (op_zero && first_oz < 0) first_oz = m_rel;
      if (rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = m_rel;
        last_rd = m_rel;
        got_addr_a.push_back(int'(rd_addr_a));
        if (exp_rd.size() > 0) begin
          m_rd = exp_rd.pop_front();
          chk("rd_addr_a", 64'(rd_addr_a), 64'(m_rd.a));
          chk("rd_addr_b", 64'(rd_addr_b), 64'(m_rd.b));
        end
      end
      if (res_valid && first_rv < 0) first_rv = m_rel;
      if (res_valid && res_ready) begin
        got_data.push_back(res_data);
        got_last.push_back(res_last);
        if (exp_res.size() > 0) begin
          m_res = exp_res.pop_front();
          chk("res_data", 64'(res_data), 64'(m_res.data));
          chk("res_last", 64'(res_last), 64'(m_res.last));
        end
      end
      if (done) begin
        n_done++;
        done_rel = m_rel;
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < DEPTH; i++)
      for (int l = 0; l < LANES; l++)
        case (mode)
          1: begin mem_a[i][l] = 8'(i + 1); mem_b[i][l] = 8'd2; end
          2: begin mem_a[i][l] = 8'(i);     mem_b[i][l] = 8'd1; end
          default: begin
            mem_a[i][l] = 8'($urandom_range(0, 255));
            mem_b[i][l] = 8'($urandom_range(0, 255));
          end
        endcase
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_cfg_ready"}, 64'(cfg_ready), 64'(1));
    chk({pfx, "_rd_en"},     64'(rd_en),     64'(0));
    chk({pfx, "_rd_addr_a"}, 64'(rd_addr_a), 64'(0));
    chk({pfx, "_rd_addr_b"}, 64'(rd_addr_b), 64'(0));
    chk({pfx, "_mac_start"}, 64'(mac_start), 64'(0));
    chk({pfx, "_mac_valid"}, 64'(mac_valid), 64'(0));
    chk({pfx, "_op_zero"},   64'(op_zero),   64'(0));
    chk({pfx, "_res_valid"}, 64'(res_valid), 64'(0));
    chk({pfx, "_res_data"},  64'(res_data),  64'(0));
    chk({pfx, "_res_last"},  64'(res_last),  64'(0));
    chk({pfx, "_busy"},      64'(busy),      64'(0));
    chk({pfx, "_done"},      64'(done),      64'(0));
  endtask

  // Builds the expected reads/results from window/beat arithmetic, then
  // presents the descriptor for one cycle (cycle 0 of the job).
  task automatic start_job(input int unsigned ab, input int unsigned bb,
                           input int unsigned sa, input int unsigned sb,
                           input int unsigned len, input int unsigned win);
    int unsigned      wa, wb, a, b;
    logic [DOT_W-1:0] sum;
    exp_res.delete(); exp_rd.delete();
    got_data.delete(); got_last.delete(); got_addr_a.delete();
    for (int unsigned w = 0; w < win; w++) begin
      wa  = (ab + w * sa) % DEPTH;
      wb  = (bb + w * sb) % DEPTH;
      sum = '0;
      for (int unsigned k = 0; k < len; k++) begin
        a = (wa + k) % DEPTH;
        b = (wb + k) % DEPTH;
        exp_rd.push_back('{a, b});
        sum += dotp(a, b);
      end
      exp_res.push_back('{sum, (w == win - 1)});
    end
    n_start = 0; n_rd = 0; n_mv = 0; n_done = 0;
    first_start = -1; first_rd = -1; last_rd = -1;
    first_oz = -1; first_rv = -1; done_rel = -1;
    cfg_a_base   = ADDR_W'(ab);
    cfg_b_base   = ADDR_W'(bb);
    cfg_a_stride = ADDR_W'(sa);
    cfg_b_stride = ADDR_W'(sb);
    cfg_len      = LEN_W'(len);
    cfg_windows  = WIN_W'(win);
    cfg_valid    = 1'b1;
    t0     = cyc;
    mon_en = 1'b1;
    chk("cfg_ready_idle", 64'(cfg_ready), 64'(1));
    tick();
    cfg_valid = 1'b0;
  endtask

  // mode 0: hold res_ready, 1: res_ready high, 2: random res_ready.
  task automatic finish_job(input int unsigned win, input int unsigned len,
                            input int mode, input int budget);
    int i;
    i = 0;
    while (n_done == 0 && i < budget) begin
      if (mode == 2) res_ready = ($urandom_range(0, 2) != 0);
      else if (mode == 1) res_ready = 1'b1;
      tick();
      i++;
    end
    chk("done_seen",        64'(n_done),            64'(1));
    chk("cfg_ready_after",  64'(cfg_ready),         64'(1));
    chk("busy_after",       64'(busy),              64'(0));
    chk("res_valid_after",  64'(res_valid),         64'(0));
    chk("mac_start_count",  64'(n_start),           64'(win));
    chk("rd_en_count",      64'(n_rd),              64'(win * len));
    chk("mac_valid_count",  64'(n_mv),              64'(win * (len + 1)));
    chk("result_count",     64'(got_data.size()),   64'(win));
    chk("reads_left",       64'(exp_rd.size()),     64'(0));
    chk("results_left",     64'(exp_res.size()),    64'(0));
    repeat (2) tick();
    chk("done_once",        64'(n_done),            64'(1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed + randomized sequence -------------------------
  initial begin : stim
    repeat (3) tick();
    check_reset_vals("por");
    rst = 1'b0;
    tick();

    // Single window: A word k lanes = k+1, B lanes = 2, len 4 -> 80.
    fill(1);
    start_job(0, 0, 0, 0, 4, 1);
    finish_job(1, 4, 1, 200);
    chk("s1_result",      64'(got_data.size() > 0 ? got_data[0] : '0), 64'(80));
    chk("s1_last",        64'(got_last.size() > 0 ? got_last[0] : 1'b0), 64'(1));
    chk("s1_mac_start_t", 64'(first_start), 64'(1));
    chk("s1_first_rd_t",  64'(first_rd),    64'(2));
    chk("s1_last_rd_t",   64'(last_rd),     64'(5));
    chk("s1_flush_t",     64'(first_oz),    64'(7));
    chk("s1_res_valid_t", 64'(first_rv),    64'(9));

    // Three windows, A stride 2, A lanes = address, B lanes = 1.
    fill(2);
    start_job(0, 0, 2, 0, 2, 3);
    finish_job(3, 2, 1, 300);
    for (int i = 0; i < 3; i++) begin
      chk("s2_result", 64'(got_data.size() > i ? got_data[i] : '0), 64'(4 + 16 * i));
      chk("s2_last",   64'(got_last.size() > i ? got_last[i] : 1'b0), 64'(i == 2));
    end

    // Backpressure: downstream stalled for 20 cycles.
    res_ready = 1'b0;
    start_job(0, 0, 2, 0, 2, 3);
    repeat (20) tick();
    chk("bp_rd_during_stall", 64'(n_rd),           64'(4));
    chk("bp_res_valid",       64'(res_valid),      64'(1));
    chk("bp_res_hold",        64'(res_data),       64'(exp_res[0].data));
    chk("bp_no_transfer",     64'(exp_res.size()), 64'(3));
    finish_job(3, 2, 1, 300);
    for (int i = 0; i < 3; i++)
      chk("bp_order", 64'(got_data.size() > i ? got_data[i] : '0), 64'(4 + 16 * i));

    // len == 0: clear, flush, drain, capture -> 0.
    fill(3);
    start_job(5, 9, 1, 1, 0, 1);
    finish_job(1, 0, 1, 200);
    chk("len0_result", 64'(got_data.size() > 0 ? got_data[0] : '1), 64'(0));

    // windows == 0: done at cycle 1, nothing else.
    start_job(5, 9, 1, 1, 3, 0);
    finish_job(0, 3, 1, 200);
    chk("win0_done_t", 64'(done_rel), 64'(1));

    // Address wrap on A.
    start_job(1022, 7, 0, 0, 4, 1);
    finish_job(1, 4, 1, 200);
    for (int i = 0; i < 4; i++)
      chk("wrap_addr_a", 64'(got_addr_a.size() > i ? got_addr_a[i] : 99999), 64'((1022 + i) % DEPTH));

    // Reset during READ of window 1 with a pending window-0 result.
    fill(2);
    res_ready = 1'b0;
    start_job(0, 0, 2, 0, 4, 3);
    for (int i = 0; i < 200 && n_start < 2; i++) tick();
    chk("mid_rd_en", 64'(rd_en), 64'(1));
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    tick();
    start_job(0, 0, 2, 0, 2, 3);
    finish_job(3, 2, 1, 300);
    for (int i = 0; i < 3; i++)
      chk("post_rst_result", 64'(got_data.size() > i ? got_data[i] : '0), 64'(4 + 16 * i));

    // Randomized jobs with random backpressure.
    fill(3);
    for (int j = 0; j < 8; j++) begin
      int unsigned len, win;
      len = $urandom_range(0, 6);
      win = $urandom_range(0, 4);
      start_job($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), len, win);
      finish_job(win, len, 2, 1500);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
